// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

    localparam int unsigned ADDR_W_DEF = 12;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } lsu_state_e;

    // Size 2'b11 behaves as a word.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] lo);
        return ((size == SZ_H) && lo[0]) || (size[1] && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU-side request bus and data-memory port of the load/store controller.
interface lsu_if
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              req;
    logic              st;
    logic [1:0]        size;
    logic              uns;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic              misalign;
    logic [31:0]       rdata;
    logic [ADDR_W-3:0] dm_addr;
    logic              dm_we;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    modport master (
        output req, st, size, uns, addr, wdata, dm_dout,
        input  ready, done, misalign, rdata, dm_addr, dm_we, dm_din
    );

    modport slave (
        input  req, st, size, uns, addr, wdata, dm_dout,
        output ready, done, misalign, rdata, dm_addr, dm_we, dm_din
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [15:0] wdata,
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0]  b_sh;
    logic [4:0]  h_sh;
    logic [7:0]  b_lane;
    logic [15:0] h_lane;
    logic [31:0] mask;

    assign b_sh   = {lo, 3'b000};
    assign h_sh   = {lo[1], 4'b0000};
    assign b_lane = 8'(dout >> b_sh);
    assign h_lane = 16'(dout >> h_sh);

    always_comb begin
        load_data  = dout;
        store_data = dout;
        mask       = '0;
        case (size)
            SZ_B: begin
                load_data  = uns ? {24'b0, b_lane} : {{24{b_lane[7]}}, b_lane};
                mask       = 32'h0000_00ff << b_sh;
                store_data = (dout & ~mask) | (32'(wdata[7:0]) << b_sh);
            end
            SZ_H: begin
                load_data  = uns ? {16'b0, h_lane} : {{16{h_lane[15]}}, h_lane};
                mask       = 32'h0000_ffff << h_sh;
                store_data = (dout & ~mask) | (32'(wdata) << h_sh);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one access per handshake, sub-word stores done as
// read-modify-write, all data-memory outputs registered.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input logic clk,
    input logic rst_n,
    lsu_if.slave bus
);

    lsu_state_e        state_q, state_d;
    logic              st_q, st_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        lo_q, lo_d;
    logic              uns_q, uns_d;
    logic              mis_q, mis_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-3:0] dm_addr_q, dm_addr_d;
    logic              dm_we_q, dm_we_d;
    logic [31:0]       dm_din_q, dm_din_d;
    logic [31:0]       load_data;
    logic [31:0]       store_data;
    logic              unused_addr;

    assign unused_addr = ^{bus.addr[31:ADDR_W], bus.wdata[31:16]};

    lsu_align u_align (
        .dout       (bus.dm_dout),
        .wdata      (wdata_q),
        .lo         (lo_q),
        .size       (size_q),
        .uns        (uns_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            st_q      <= 1'b0;
            size_q    <= SZ_B;
            lo_q      <= 2'b00;
            uns_q     <= 1'b0;
            mis_q     <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            dm_addr_q <= '0;
            dm_we_q   <= 1'b0;
            dm_din_q  <= '0;
        end else begin
            state_q   <= state_d;
            st_q      <= st_d;
            size_q    <= size_d;
            lo_q      <= lo_d;
            uns_q     <= uns_d;
            mis_q     <= mis_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            dm_addr_q <= dm_addr_d;
            dm_we_q   <= dm_we_d;
            dm_din_q  <= dm_din_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        size_d    = size_q;
        lo_d      = lo_q;
        uns_d     = uns_q;
        mis_d     = mis_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        dm_addr_d = dm_addr_q;
        dm_we_d   = dm_we_q;
        dm_din_d  = dm_din_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    st_d      = bus.st;
                    size_d    = bus.size;
                    lo_d      = bus.addr[1:0];
                    uns_d     = bus.uns;
                    wdata_d   = bus.wdata[15:0];
                    dm_addr_d = bus.addr[ADDR_W-1:2];
                    mis_d     = is_misaligned(bus.size, bus.addr[1:0]);
                    // Misaligned accesses idle through READ to keep a 3-cycle turnaround.
                    if (!mis_d && bus.st && bus.size[1]) begin
                        dm_din_d = bus.wdata;
                        dm_we_d  = 1'b1;
                        state_d  = StWrite;
                    end else begin
                        state_d  = StRead;
                    end
                end
            end
            StRead: begin
                if (mis_q) begin
                    state_d = StDone;
                end else if (!st_q) begin
                    rdata_d = load_data;
                    state_d = StDone;
                end else begin
                    dm_din_d = store_data;
                    dm_we_d  = 1'b1;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                dm_we_d = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                mis_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.ready    = (state_q == StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.misalign = mis_q && (state_q == StDone);
    assign bus.rdata    = rdata_q;
    assign bus.dm_addr  = dm_addr_q;
    assign bus.dm_we    = dm_we_q;
    assign bus.dm_din   = dm_din_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed test-plan cases plus random accesses checked
// against a byte-level reference model of the memory and load result.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_load;

    lsu_if #(.ADDR_W(12)) bus ();

    lsu_ctrl #(.ADDR_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_rdata;
    int n_checks = 0;
    int n_errors = 0;

    assign bus.dm_dout = mem[bus.dm_addr];

    always @(negedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
        end else if (bus.dm_we) begin
            mem[bus.dm_addr] <= bus.dm_din;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: memory as bytes, little-endian lanes.
    task automatic model_op(input logic st, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic mis, output int wes);
        int lo;
        int idx;
        logic [7:0] b[4];
        logic [31:0] v;
        bit word;
        lo   = int'(addr[1:0]);
        idx  = int'(addr[11:2]);
        word = (size >= 2'd2);
        mis  = ((size == 2'd1) && (lo % 2 == 1)) || (word && lo != 0);
        lat  = 2;
        wes  = 0;
        for (int i = 0; i < 4; i++) b[i] = ref_mem[idx][8*i +: 8];
        if (mis) return;
        if (!st) begin
            if (word) begin
                ref_rdata = ref_mem[idx];
            end else if (size == 2'd0) begin
                v = {24'b0, b[lo]};
                if (!uns && b[lo][7]) v = v | 32'hffff_ff00;
                ref_rdata = v;
            end else begin
                v = {16'b0, b[lo+1], b[lo]};
                if (!uns && b[lo+1][7]) v = v | 32'hffff_0000;
                ref_rdata = v;
            end
        end else begin
            wes = 1;
            if (word) begin
                ref_mem[idx] = wdata;
            end else begin
                lat   = 3;
                b[lo] = wdata[7:0];
                if (size == 2'd1) b[lo+1] = wdata[15:8];
                ref_mem[idx] = {b[3], b[2], b[1], b[0]};
            end
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!bus.ready && k < 10) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input string tag, input logic st, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        int lat_obs = 0;
        int we_obs = 0;
        int lat_exp;
        int we_exp;
        logic mis_obs = 1'b0;
        logic mis_exp;
        wait_ready();
        bus.st    = st;
        bus.size  = size;
        bus.uns   = uns;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.req   = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.dm_we) we_obs++;
            if (bus.done) begin
                lat_obs = n;
                mis_obs = bus.misalign;
                break;
            end
        end
        model_op(st, size, uns, addr, wdata, lat_exp, mis_exp, we_exp);
        check_eq({tag, "_lat"}, 32'(lat_obs), 32'(lat_exp));
        check_eq({tag, "_mis"}, 32'(mis_obs), 32'(mis_exp));
        check_eq({tag, "_we"}, 32'(we_obs), 32'(we_exp));
        check_eq({tag, "_rdata"}, bus.rdata, ref_rdata);
        check_eq({tag, "_mem"}, mem[addr[11:2]], ref_mem[addr[11:2]]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat_e;
        int we_e;
        int we_obs;
        logic mis_e;
        logic [7:0] done_mask;
        logic [31:0] a;

        bus.req = 1'b0; bus.st = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        rst_n = 1'b0;
        ref_rdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'h8899_aabb;
        ref_mem[1] = 32'h1122_3344;
        mem_load = 1'b1;
        #2;
        check_eq("rst_ready", 32'(bus.ready), 32'd1);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_mis", 32'(bus.misalign), 32'd0);
        check_eq("rst_rdata", bus.rdata, 32'd0);
        check_eq("rst_we", 32'(bus.dm_we), 32'd0);
        check_eq("rst_addr", 32'(bus.dm_addr), 32'd0);
        check_eq("rst_din", bus.dm_din, 32'd0);
        repeat (2) @(negedge clk);
        mem_load = 1'b0;
        rst_n = 1'b1;

        // Loads from word0
        run_op("lb", 1'b0, 2'd0, 1'b0, 32'h003, '0);
        check_eq("lb_val", bus.rdata, 32'hffff_ff88);
        run_op("lbu", 1'b0, 2'd0, 1'b1, 32'h003, '0);
        check_eq("lbu_val", bus.rdata, 32'h0000_0088);
        run_op("lh", 1'b0, 2'd1, 1'b0, 32'h000, '0);
        check_eq("lh_val", bus.rdata, 32'hffff_aabb);
        run_op("lhu", 1'b0, 2'd1, 1'b1, 32'h002, '0);
        check_eq("lhu_val", bus.rdata, 32'h0000_8899);

        // Sub-word stores into word1
        run_op("sh", 1'b1, 2'd1, 1'b0, 32'h006, 32'h0000_1234);
        check_eq("sh_val", mem[1], 32'h1234_3344);
        run_op("sb", 1'b1, 2'd0, 1'b0, 32'h004, 32'h0000_00ab);
        check_eq("sb_val", mem[1], 32'h1234_33ab);

        // Misaligned
        run_op("lw_mis", 1'b0, 2'd2, 1'b0, 32'h00a, '0);
        run_op("sh_mis", 1'b1, 2'd1, 1'b0, 32'h001, 32'hffff_ffff);
        check_eq("mis_rdata", bus.rdata, 32'h0000_8899);

        // SW at top of memory then LW with req held high
        wait_ready();
        bus.st = 1'b1; bus.size = 2'd2; bus.uns = 1'b0;
        bus.addr = 32'habcd_effc; bus.wdata = 32'hdead_beef; bus.req = 1'b1;
        @(posedge clk);
        #1 bus.st = 1'b0;
        done_mask = '0;
        we_obs = 0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (bus.done) done_mask[n] = 1'b1;
            if (bus.dm_we) we_obs++;
            if (n == 4) bus.req = 1'b0;
        end
        model_op(1'b1, 2'd2, 1'b0, 32'habcd_effc, 32'hdead_beef, lat_e, mis_e, we_e);
        model_op(1'b0, 2'd2, 1'b0, 32'habcd_effc, '0, lat_e, mis_e, we_e);
        check_eq("held_done", 32'(done_mask), 32'h24);
        check_eq("held_we", 32'(we_obs), 32'd1);
        check_eq("held_rdata", bus.rdata, ref_rdata);
        check_eq("held_val", bus.rdata, 32'hdead_beef);
        check_eq("held_mem", mem[1023], ref_mem[1023]);

        // Reset during the WRITE cycle of a byte store
        wait_ready();
        bus.st = 1'b1; bus.size = 2'd0; bus.addr = 32'h005; bus.wdata = 32'h55; bus.req = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rw_we_pre", 32'(bus.dm_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rw_we", 32'(bus.dm_we), 32'd0);
        check_eq("rw_ready", 32'(bus.ready), 32'd1);
        check_eq("rw_done", 32'(bus.done), 32'd0);
        check_eq("rw_rdata", bus.rdata, 32'd0);
        check_eq("rw_addr", 32'(bus.dm_addr), 32'd0);
        check_eq("rw_din", bus.dm_din, 32'd0);
        ref_rdata = '0;
        repeat (2) @(negedge clk);
        check_eq("rw_mem", mem[1], ref_mem[1]);
        rst_n = 1'b1;
        #1;
        check_eq("rw_ready_rel", 32'(bus.ready), 32'd1);
        @(negedge clk);
        check_eq("rw_idle_done", 32'(bus.done), 32'd0);
        run_op("post_rst_lw", 1'b0, 2'd2, 1'b0, 32'h004, '0);

        // Random accesses over a small window to provoke reuse
        for (int i = 0; i < 60; i++) begin
            a = ($urandom & 32'hffff_f003) | (32'($urandom_range(0, 15)) << 2);
            run_op("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
